// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch core: direction codes used by
// both the fill-stage direction writer and the traceback walker, plus the
// traceback state encoding.
package nw_pkg;

  // Direction-matrix codes.
  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_NONE = 2'b11;

  // Traceback walker states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_STEP = 2'd2,
    ST_FIN  = 2'd3
  } tb_state_e;

endpackage

// File: rtl/tb_move_decode.sv
// Boundary-forcing move decode. On the left edge (column 0) only an up move
// is possible. On the top edge (row 0) only a left move is possible.
// Otherwise the direction-matrix code passes through unchanged. The output
// writer reuses this block.
module tb_move_decode
  import nw_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_row,
  input  logic [W-1:0] i_col,
  input  logic [1:0]   i_dir,
  output logic [1:0]   o_move
);

  // Column 0 takes priority, so the origin itself decodes as up.
  // The walker never decodes at the origin.
  always_comb begin
    // NOTE: assign a default first so every path drives o_move and no latch is inferred.
    o_move = i_dir;
    if (i_col == '0) begin
      o_move = DIR_UP;
    end else if (i_row == '0) begin
      o_move = DIR_LEFT;
    end
  end

endmodule

// File: rtl/traceback_index_gen.sv
// Traceback address walker. After the matrix fill, it walks (i_t, j_t) from
// (N,N) to (0,0). Each move reads the direction matrix once and takes two
// cycles (READ presents the address, STEP consumes the data). The walker
// emits one committed move per step.
module traceback_index_gen
  import nw_pkg::*;
#(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         dir_in,
  output logic [BitAddr:0]   i_t,
  output logic [BitAddr:0]   j_t,
  output logic               en_traceB,
  output logic               dir_rd,
  output logic               step_valid,
  output logic [1:0]         move,
  output logic [BitAddr+1:0] step_cnt,
  output logic               done,
  output logic               err
);

  localparam int              IdxW  = BitAddr + 1;
  localparam int              CntW  = BitAddr + 2;
  localparam logic [IdxW-1:0] IdxN  = IdxW'(N);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  tb_state_e       r_state;
  logic [IdxW-1:0] r_i;
  logic [IdxW-1:0] r_j;
  logic [CntW-1:0] r_cnt;
  logic            r_en;
  logic            r_rd;
  logic            r_done;
  logic            r_err;

  logic [1:0]      w_move;
  logic            w_at_origin;
  logic            w_dec_i;
  logic            w_dec_j;
  logic [IdxW-1:0] w_i_nxt;
  logic [IdxW-1:0] w_j_nxt;
  logic            w_nxt_origin;

  tb_move_decode #(.W(IdxW)) u_move_decode (
    .i_row  (r_i),
    .i_col  (r_j),
    .i_dir  (dir_in),
    .o_move (w_move)
  );

  assign w_at_origin  = (r_i == '0) && (r_j == '0);
  assign w_dec_i      = (w_move == DIR_DIAG) || (w_move == DIR_UP);
  assign w_dec_j      = (w_move == DIR_DIAG) || (w_move == DIR_LEFT);
  assign w_i_nxt      = w_dec_i ? (r_i - IdxOne) : r_i;
  assign w_j_nxt      = w_dec_j ? (r_j - IdxOne) : r_j;
  assign w_nxt_origin = (w_i_nxt == '0) && (w_j_nxt == '0);

  // Walker FSM with registered strobes and index/counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_rd    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i     <= IdxN;
            r_j     <= IdxN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_en    <= 1'b1;
            r_rd    <= 1'b1;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_rd <= 1'b0;
          if (w_at_origin) begin
            r_en    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (w_move == DIR_NONE) begin
            r_err   <= 1'b1;
            r_en    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_cnt   <= r_cnt + CntOne;
            r_rd    <= !w_nxt_origin;
            r_state <= ST_READ;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The commit strobe and move depend on this cycle's read data, so they
  // are decoded from the STEP state rather than registered.
  assign step_valid = (r_state == ST_STEP) && (w_move != DIR_NONE);
  assign move       = (r_state == ST_STEP) ? w_move : DIR_DIAG;

  assign i_t       = r_i;
  assign j_t       = r_j;
  assign step_cnt  = r_cnt;
  assign en_traceB = r_en;
  assign dir_rd    = r_rd;
  assign done      = r_done;
  assign err       = r_err;

endmodule
